// File: rtl/multicycle_memory_bridge.sv
// multicycle_memory_bridge
//   Turns one sized RISC-V load/store request from the multicycle datapath into a
//   single word-aligned ready/valid bus transaction. Holds the bus request stable
//   through wait states, then returns sign/zero-extended load data with a
//   one-cycle done pulse that releases the control FSM from its stall.
//
//   Parameter MAX_WAIT: ACCESS cycles without bus_ready before aborting with
//   error (0 = wait forever).
//   Optional macro MEMORY_BRIDGE_ALIGNMENT_CHECK_EN: rejects misaligned H/HU/W and
//   funct3 011/110/111 without touching the bus (done+error two cycles after the
//   request). When undefined, no check is made and odd funct3 codes act as W.
//
//   Ports
//     clock, reset                 core clock, async active-high reset
//     req_valid/write/funct3/address/write_data   request, sampled in IDLE only
//     busy, done, error, read_data                status / load result
//     bus_valid/write/address/byte_enable/write_data, bus_ready, bus_read_data
//                                                  word-aligned bus port

// Per byte-lane enable and store-data steering.
module bridge_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  always_comb begin
    be    = 1'b1;
    wbyte = wdata[8*LANE +: 8];
    case (funct3[1:0])
      2'b00: begin
        be    = (addr_lo == 2'(LANE));
        wbyte = wdata[7:0];
      end
      2'b01: begin
        // Odd halfword addresses still land in half lane addr[1].
        be    = (addr_lo[1] == LANE[1]);
        wbyte = wdata[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module multicycle_memory_bridge #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] read_data,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data
);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [2:0]         f3_q;
  logic [1:0]         a_q;
  logic               rej_q;
  logic               err_q;
  logic [CW-1:0]      cnt, cnt_inc;
  logic               timeout;
  logic               reject;
  logic [3:0]         be_nxt;
  logic [3:0][7:0]    wd_nxt;
  logic [7:0]         lbyte;
  logic [15:0]        lhalf;
  logic [31:0]        load_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    bridge_byte_lane #(.LANE(gi)) u_lane (
      .funct3  (req_funct3),
      .addr_lo (req_address[1:0]),
      .wdata   (req_write_data),
      .be      (be_nxt[gi]),
      .wbyte   (wd_nxt[gi])
    );
  end

`ifdef MEMORY_BRIDGE_ALIGNMENT_CHECK_EN
  always_comb begin
    reject = 1'b0;
    case (req_funct3)
      3'b001, 3'b101: reject = req_address[0];
      3'b010:         reject = (req_address[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: reject = 1'b1;
      default:        reject = 1'b0;
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  assign cnt_inc = cnt + 1'b1;
  assign timeout = (MAX_WAIT != 0) && (32'(cnt_inc) == MAX_WAIT);

  assign lbyte = 8'(bus_read_data >> {a_q, 3'b000});
  assign lhalf = 16'(bus_read_data >> {a_q[1], 4'b0000});

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{lbyte[7]}}, lbyte};
      3'b001:  load_ext = {{16{lhalf[15]}}, lhalf};
      3'b100:  load_ext = {24'b0, lbyte};
      3'b101:  load_ext = {16'b0, lhalf};
      default: load_ext = bus_read_data;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A rejected request still spends one cycle in ACCESS (bus_valid held low) so
  // its done lands two cycles after req_valid, like a zero-wait access.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    bus_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:   if (req_valid) state_nxt = ACCESS;
      ACCESS: begin
        bus_valid = !rej_q;
        if (rej_q || bus_ready || timeout) state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign error = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f3_q            <= '0;
      a_q             <= '0;
      rej_q           <= 1'b0;
      err_q           <= 1'b0;
      cnt             <= '0;
      read_data       <= '0;
      bus_write       <= 1'b0;
      bus_address     <= '0;
      bus_byte_enable <= '0;
      bus_write_data  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q            <= req_funct3;
          a_q             <= req_address[1:0];
          rej_q           <= reject;
          cnt             <= '0;
          bus_write       <= req_write;
          bus_address     <= {req_address[31:2], 2'b00};
          bus_byte_enable <= be_nxt;
          bus_write_data  <= wd_nxt;
        end
        ACCESS: begin
          if (rej_q) begin
            err_q <= 1'b1;
          end else if (bus_ready) begin
            err_q <= 1'b0;
            if (!bus_write) read_data <= load_ext;
          end else begin
            cnt <= cnt_inc;
            if (timeout) err_q <= 1'b1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_memory_bridge.sv
// Scoreboard bench for multicycle_memory_bridge: directed requests push their
// expected bus transaction and response; monitors compare on bus_valid / done.
module tb_multicycle_memory_bridge;
  localparam int MAXW = 6;
`ifdef MEMORY_BRIDGE_ALIGNMENT_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0, req_write_data = '0;
  logic        busy, done, error, bus_valid, bus_write;
  logic [31:0] read_data, bus_address, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = '0;

  multicycle_memory_bridge #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_address(req_address), .req_write_data(req_write_data),
    .busy(busy), .done(done), .error(error), .read_data(read_data),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rd; int cyc; } resp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } busx_t;
  resp_t resp_q[$];
  busx_t bus_q[$];

  int checks = 0, errors = 0;
  int bus_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: ready after bus_wait cycles of bus_valid; negative = never.
  int bcnt = 0;
  always @(negedge clock) begin
    if (bus_valid) begin
      bus_ready = (bus_wait >= 0) && (bcnt == bus_wait);
      bcnt++;
    end else begin
      bus_ready = 1'b0;
      bcnt = 0;
    end
  end

  // Bus monitor: first cycle of a request checked against queue, then stability.
  logic bv_prev = 1'b0;
  busx_t cur;
  always @(negedge clock) begin : mon_bus
    if (bus_valid) begin
      if (!bv_prev) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus: addr %h be %b", bus_address, bus_byte_enable);
        end else begin
          cur = bus_q.pop_front();
          chk("bus_write", 32'(bus_write), 32'(cur.wr));
          chk("bus_address", bus_address, cur.addr);
          chk("bus_byte_enable", 32'(bus_byte_enable), 32'(cur.be));
          chk("bus_write_data", bus_write_data, cur.wd);
        end
      end else begin
        chk("bus_addr_stable", bus_address, cur.addr);
        chk("bus_be_stable", 32'(bus_byte_enable), 32'(cur.be));
        chk("bus_wd_stable", bus_write_data, cur.wd);
      end
    end
    bv_prev = bus_valid;
  end

  // Response monitor.
  logic done_prev = 1'b0;
  resp_t e;
  always @(negedge clock) begin : mon_resp
    if (done) begin
      chk("done_pulse", 32'(done_prev), 32'd0);
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        e = resp_q.pop_front();
        chk("error", 32'(error), 32'(e.err));
        chk("read_data", read_data, e.rd);
        chk("done_cycle", cyc, e.cyc);
      end
    end
    done_prev = done;
  end

  task automatic wait_drain();
    int k;
    for (k = 0; k < 40 && resp_q.size() != 0; k++) begin
      @(negedge clock); #1;
    end
    if (resp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected %0d pending", resp_q.size());
      resp_q.delete();
      bus_q.delete();
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] brd, input int waits,
                        input logic rej, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_bwd);
    resp_t r;
    busx_t b;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3;
    req_address = addr; req_write_data = wd;
    bus_read_data = brd; bus_wait = waits;
    r.err = rej || (waits < 0);
    r.rd  = exp_rd;
    r.cyc = cyc + (rej ? 2 : (waits < 0 ? 1 + MAXW : 2 + waits));
    resp_q.push_back(r);
    if (!rej) begin
      b.wr = wr; b.addr = {addr[31:2], 2'b00}; b.be = exp_be; b.wd = exp_bwd;
      bus_q.push_back(b);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    busx_t b;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_bus_write", 32'(bus_write), 0);
    chk("rst_be", 32'(bus_byte_enable), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_address", bus_address, 0);
    chk("rst_bus_wdata", bus_write_data, 0);
    reset = 1'b0;

    //      wr    f3      addr        wdata         bus rdata     wt  rej  exp rd        be       bus wdata
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,         0, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h103, 32'h12345678, 32'h0,         0, 1'b0, 32'h0,        4'b1000, 32'h78787878);
    do_req(1'b0, 3'b000, 32'h102, 32'h0,        32'h00800000,  0, 1'b0, 32'hFFFFFF80, 4'b0100, 32'h0);
    do_req(1'b0, 3'b100, 32'h102, 32'h0,        32'h00800000,  0, 1'b0, 32'h00000080, 4'b0100, 32'h0);
    do_req(1'b0, 3'b101, 32'h102, 32'h0,        32'hBEEF1234,  5, 1'b0, 32'h0000BEEF, 4'b1100, 32'h0);
    do_req(1'b0, 3'b001, 32'h100, 32'h0,        32'h12348001,  0, 1'b0, 32'hFFFF8001, 4'b0011, 32'h0);
    do_req(1'b1, 3'b001, 32'h102, 32'hAAAA5555, 32'h0,         2, 1'b0, 32'hFFFF8001, 4'b1100, 32'h55555555);
    do_req(1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D,  1, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0);
    do_req(1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00,  0, 1'b0, 32'h0000007F, 4'b0010, 32'h0);
    // bus never ready: timeout, read_data kept
    do_req(1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        -1, 1'b0, 32'h0000007F, 4'b1111, 32'h0);
    // misaligned / odd funct3: no check by default, rejected when the check is built in
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, ACHK,
           ACHK ? 32'h0000007F : 32'h11223344, 4'b1111, 32'h0);
    do_req(1'b0, 3'b101, 32'h103, 32'h0, 32'hBEEF0000, 0, ACHK,
           ACHK ? 32'h0000007F : 32'h0000BEEF, 4'b1100, 32'h0);
    do_req(1'b0, 3'b011, 32'h108, 32'h0, 32'h55AA55AA, 0, ACHK,
           ACHK ? 32'h0000007F : 32'h55AA55AA, 4'b1111, 32'h0);

    // reset in the middle of an access
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_address = 32'h300; bus_wait = -1;
    b.wr = 1'b0; b.addr = 32'h300; b.be = 4'b1111; b.wd = 32'h0;
    bus_q.push_back(b);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid_bus_valid_before", 32'(bus_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_bus_valid", 32'(bus_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_read_data", read_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    do_req(1'b1, 3'b010, 32'h010, 32'h01020304, 32'h0,        1, 1'b0, 32'h0,        4'b1111, 32'h01020304);
    do_req(1'b0, 3'b001, 32'h012, 32'h0,        32'h80000000, 0, 1'b0, 32'hFFFF8000, 4'b1100, 32'h0);

    repeat (3) @(posedge clock);
    #1;
    chk("queues_empty", 32'(resp_q.size() + bus_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
